// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch queue bus: instruction memory, decode and redirect signals
interface instr_fetch_queue_if;
    logic        IM_req;
    logic [31:0] IM_addr;
    logic [31:0] IM_rdata;
    logic        IFQ_valid;
    logic [31:0] IFQ_Instr;
    logic [31:0] IFQ_PC;
    logic        IFQ_pred_taken;
    logic        DU_ready;
    logic        EX_redirect;
    logic [31:0] EX_target;

    modport master (
        output IM_req, IM_addr, IFQ_valid, IFQ_Instr, IFQ_PC, IFQ_pred_taken,
        input  IM_rdata, DU_ready, EX_redirect, EX_target
    );

    modport slave (
        input  IM_req, IM_addr, IFQ_valid, IFQ_Instr, IFQ_PC, IFQ_pred_taken,
        output IM_rdata, DU_ready, EX_redirect, EX_target
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential fetch into a DEPTH-entry instruction FIFO; IFQ_STATIC_PREDICT_EN adds JAL predecode
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_queue_if.master    bus
);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW+1:0]   DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [6:0]      JAL_OPC = 7'b1101111;

    logic [31:0]   fetch_pc;
    logic          pending;
    logic [31:0]   pending_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          push;
    logic          pop;
    logic          issue;
    logic          jal_hit;
    logic          head_pred;
    logic [AW+1:0] occupancy;

    // Occupancy counts the in-flight response so a push can never land on a full FIFO
    assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, pending};
    assign push      = pending && !bus.EX_redirect;

`ifdef IFQ_STATIC_PREDICT_EN
    logic        pred_mem [DEPTH];
    logic [31:0] jal_target;

    assign jal_hit    = push && (bus.IM_rdata[6:0] == JAL_OPC);
    assign jal_target = pending_pc + {{11{bus.IM_rdata[31]}}, bus.IM_rdata[31], bus.IM_rdata[19:12],
                                      bus.IM_rdata[20], bus.IM_rdata[30:21], 1'b0};
    assign head_pred  = pred_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            pred_mem[wr_ptr] <= jal_hit;
        end
    end
`else
    assign jal_hit   = 1'b0;
    assign head_pred = 1'b0;
`endif

    assign issue = !rst && !bus.EX_redirect && !jal_hit && (occupancy < DEPTH_W);

    assign bus.IM_req         = issue;
    assign bus.IM_addr        = fetch_pc;
    assign bus.IFQ_valid      = (count != '0) && !bus.EX_redirect;
    assign bus.IFQ_Instr      = bus.IFQ_valid ? instr_mem[rd_ptr] : 32'h0;
    assign bus.IFQ_PC         = bus.IFQ_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign bus.IFQ_pred_taken = bus.IFQ_valid && head_pred;
    assign pop                = bus.IFQ_valid && bus.DU_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.IM_rdata;
            pc_mem[wr_ptr]    <= pending_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= 32'h0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else if (bus.EX_redirect) begin
            fetch_pc <= {bus.EX_target[31:2], 2'b00};
            pending  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            pending <= issue;
            if (issue) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd4;
            end
`ifdef IFQ_STATIC_PREDICT_EN
            else if (jal_hit) begin
                fetch_pc <= jal_target;
            end
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized bench for instr_fetch_queue against a queue-based program-order model
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_STATIC_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: next fetch address, one in-flight request, and the FIFO as a queue of PCs
    logic [31:0] m_fetch;
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] q[$];
    bit          jal_en;
    logic [31:0] jal_addr;
    logic [31:0] jal_tgt;
    bit          last_req;
    logic [31:0] last_addr;
    int          req_cnt;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_jal(logic [31:0] pc);
        return jal_en && (pc == jal_addr);
    endfunction

    // Memory contents: address-tagged ALU ops, except an optional JAL with imm +0x20
    function automatic logic [31:0] mem_word(logic [31:0] pc);
        if (is_jal(pc)) return 32'h0200_006F;
        return {pc[26:2], 7'b0010011};
    endfunction

    task automatic model_reset();
        m_fetch    = RESET_PC;
        m_inflight = 1'b0;
        q.delete();
        last_req   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req",   {31'h0, bus.IM_req}, 32'h0);
        check("rst_valid", {31'h0, bus.IFQ_valid}, 32'h0);
        check("rst_pred",  {31'h0, bus.IFQ_pred_taken}, 32'h0);
        check("rst_instr", bus.IFQ_Instr, 32'h0);
        check("rst_pc",    bus.IFQ_PC, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge: drive inputs, check outputs, advance the model, move to the next negedge
    task automatic cycle(bit du, bit redir, logic [31:0] tgt);
        bit          jal_push;
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] head;
        bus.DU_ready    = du;
        bus.EX_redirect = redir;
        bus.EX_target   = tgt;
        bus.IM_rdata    = last_req ? mem_word(last_addr) : $urandom;
        #1;
        jal_push  = PRED_EN && m_inflight && !redir && is_jal(m_inflight_pc);
        exp_req   = !redir && !jal_push && ((q.size() + int'(m_inflight)) < DEPTH);
        exp_valid = (q.size() != 0) && !redir;
        head      = (q.size() != 0) ? q[0] : 32'h0;
        check("im_req", {31'h0, bus.IM_req}, {31'h0, exp_req});
        if (exp_req) check("im_addr", bus.IM_addr, m_fetch);
        check("ifq_valid", {31'h0, bus.IFQ_valid}, {31'h0, exp_valid});
        check("ifq_pc",    bus.IFQ_PC,    exp_valid ? head : 32'h0);
        check("ifq_instr", bus.IFQ_Instr, exp_valid ? mem_word(head) : 32'h0);
        check("ifq_pred",  {31'h0, bus.IFQ_pred_taken},
              {31'h0, exp_valid && PRED_EN && is_jal(head)});
        last_req  = bus.IM_req;
        last_addr = bus.IM_addr;
        if (bus.IM_req) req_cnt++;
        if (redir) begin
            q.delete();
            m_inflight = 1'b0;
            m_fetch    = {tgt[31:2], 2'b00};
        end else begin
            if (exp_valid && du) void'(q.pop_front());
            if (m_inflight) q.push_back(m_inflight_pc);
            if (exp_req) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_fetch;
                m_fetch       = m_fetch + 32'd4;
            end else begin
                m_inflight = 1'b0;
                if (jal_push) m_fetch = jal_tgt;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.DU_ready    = 1'b0;
        bus.EX_redirect = 1'b0;
        bus.EX_target   = 32'h0;
        bus.IM_rdata    = 32'h0;
        jal_en          = 1'b0;
        jal_addr        = 32'h8;
        jal_tgt         = 32'h28;
        last_addr       = 32'h0;
        m_inflight_pc   = 32'h0;
        req_cnt         = 0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Streaming with decode always ready
        repeat (20) cycle(1'b1, 1'b0, 32'h0);

        // Decode stalled from reset: exactly DEPTH requests, then drain and resume
        do_reset();
        req_cnt = 0;
        repeat (12) cycle(1'b0, 1'b0, 32'h0);
        check("full_reqs", req_cnt, DEPTH);
        repeat (12) cycle(1'b1, 1'b0, 32'h0);

        // Full queue with a single-cycle pop
        repeat (8) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);

        // Redirect to an unaligned target with a response in flight and three entries queued
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // Fetch address wraparound, then back-to-back redirects
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0400);
        cycle(1'b1, 1'b1, 32'h0000_0800);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Random decode back-pressure and redirects
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), $urandom & 32'h0000_0FFF);
        end

        // Reset mid-stream with two entries queued and one in flight
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        do_reset();
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // JAL at 0x8 with imm +0x20
        do_reset();
        jal_en = 1'b1;
        repeat (20) cycle(1'b1, 1'b0, 32'h0);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);
        jal_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
